// File: rtl/rggen_sw_access_arbiter.sv
// rggen_sw_access_arbiter
//   Round-robin arbiter sharing the register block's software access port
//   between N valid/ready requesters. One access is in flight at a time; the
//   winning request is latched on grant and held on o_reg_* until the
//   register block (or the optional timeout) completes it.
//   Optional feature: define RGGEN_ARB_TIMEOUT_EN to add a response timeout
//   that completes a stalled access with SLAVE_ERROR after TIMEOUT_CYCLES.
module rggen_sw_access_arbiter #(
  parameter int N              = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N-1:0]               i_req_valid,
  input  logic [N-1:0]               i_req_write,
  input  logic [N*ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [N*DATA_WIDTH-1:0]    i_req_write_data,
  input  logic [N*DATA_WIDTH-1:0]    i_req_strobe,
  output logic [N-1:0]               o_req_ready,
  output logic [1:0]                 o_req_status,
  output logic [DATA_WIDTH-1:0]      o_req_read_data,
  output logic                       o_reg_valid,
  output logic                       o_reg_write,
  output logic [ADDRESS_WIDTH-1:0]   o_reg_address,
  output logic [DATA_WIDTH-1:0]      o_reg_write_data,
  output logic [DATA_WIDTH-1:0]      o_reg_strobe,
  input  logic                       i_reg_ready,
  input  logic [1:0]                 i_reg_status,
  input  logic [DATA_WIDTH-1:0]      i_reg_read_data
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Elaboration-time parameter range guards
  if (N < 2 || N > 8) begin : g_check_n
    $error("rggen_sw_access_arbiter: N must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_check_timeout
    $error("rggen_sw_access_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [IDX_W-1:0]          ptr_reg, ptr_next;
  logic [IDX_W-1:0]          grant_reg, grant_next;
  logic                      write_reg, write_next;
  logic [ADDRESS_WIDTH-1:0]  address_reg, address_next;
  logic [DATA_WIDTH-1:0]     write_data_reg, write_data_next;
  logic [DATA_WIDTH-1:0]     strobe_reg, strobe_next;

  logic                      busy;
  logic                      timeout_hit;
  logic                      complete;
  logic                      sel_found;
  logic [IDX_W-1:0]          sel_idx;
  logic [IDX_W-1:0]          cand_idx;

  // Per-requester views of the packed request buses
  logic [ADDRESS_WIDTH-1:0]  req_address [N];
  logic [DATA_WIDTH-1:0]     req_write_data [N];
  logic [DATA_WIDTH-1:0]     req_strobe [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign req_address[gi]    = i_req_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign req_write_data[gi] = i_req_write_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_strobe[gi]     = i_req_strobe[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign busy = (state_reg == BUSY);

`ifdef RGGEN_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count_reg, count_next;

  // A real response in the same cycle as the limit takes precedence
  assign timeout_hit = busy && !i_reg_ready && (count_reg == TIMEOUT_LIMIT);

  // Count stalled BUSY cycles; held at zero outside BUSY so each access starts fresh
  always_comb begin
    count_next = 16'd0;
    if (busy && !i_reg_ready && !timeout_hit) begin
      count_next = count_reg + 16'd1;
    end
  end

  // Timeout counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg <= 16'd0;
    end else begin
      count_reg <= count_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign complete = busy && (i_reg_ready || timeout_hit);

  // Round-robin pick: first valid requester at or after (ptr+1) mod N
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int i = 1; i <= N; i++) begin
      cand_idx = IDX_W'((int'(ptr_reg) + i) % N);
      if (!sel_found && i_req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: grant and latch in IDLE, release and rotate on completion
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    grant_next      = grant_reg;
    write_next      = write_reg;
    address_next    = address_reg;
    write_data_next = write_data_reg;
    strobe_next     = strobe_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next      = BUSY;
          grant_next      = sel_idx;
          write_next      = i_req_write[sel_idx];
          address_next    = req_address[sel_idx];
          write_data_next = req_write_data[sel_idx];
          strobe_next     = req_strobe[sel_idx];
        end
      end
      BUSY: begin
        if (complete) begin
          state_next = IDLE;
          ptr_next   = grant_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer and latched request registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      ptr_reg        <= IDX_W'(N - 1);
      grant_reg      <= '0;
      write_reg      <= 1'b0;
      address_reg    <= '0;
      write_data_reg <= '0;
      strobe_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      grant_reg      <= grant_next;
      write_reg      <= write_next;
      address_reg    <= address_next;
      write_data_reg <= write_data_next;
      strobe_reg     <= strobe_next;
    end
  end

  // Register-block side is driven straight from the latches
  assign o_reg_valid      = busy;
  assign o_reg_write      = write_reg;
  assign o_reg_address    = address_reg;
  assign o_reg_write_data = write_data_reg;
  assign o_reg_strobe     = strobe_reg;

  // Response is passed through only in the completion cycle; timeout reports SLAVE_ERROR
  always_comb begin
    o_req_status    = 2'b00;
    o_req_read_data = '0;
    if (busy && i_reg_ready) begin
      o_req_status    = i_reg_status;
      o_req_read_data = i_reg_read_data;
    end else if (complete) begin
      o_req_status    = 2'b10;
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign o_req_ready[gi] = complete && (grant_reg == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_rggen_sw_access_arbiter.sv
// Directed testbench for rggen_sw_access_arbiter (N=3, TIMEOUT_CYCLES=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. The timeout scenario runs only when RGGEN_ARB_TIMEOUT_EN
// is defined.
module tb_rggen_sw_access_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_write_data;
  logic [N*DW-1:0] req_strobe;
  logic [N-1:0]    req_ready;
  logic [1:0]      req_status;
  logic [DW-1:0]   req_read_data;
  logic            reg_valid;
  logic            reg_write;
  logic [AW-1:0]   reg_address;
  logic [DW-1:0]   reg_write_data;
  logic [DW-1:0]   reg_strobe;
  logic            reg_ready;
  logic [1:0]      reg_status;
  logic [DW-1:0]   reg_read_data;

  int checks = 0;
  int errors = 0;

  rggen_sw_access_arbiter #(
    .N              (N),
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_valid      (req_valid),
    .i_req_write      (req_write),
    .i_req_address    (req_address),
    .i_req_write_data (req_write_data),
    .i_req_strobe     (req_strobe),
    .o_req_ready      (req_ready),
    .o_req_status     (req_status),
    .o_req_read_data  (req_read_data),
    .o_reg_valid      (reg_valid),
    .o_reg_write      (reg_write),
    .o_reg_address    (reg_address),
    .o_reg_write_data (reg_write_data),
    .o_reg_strobe     (reg_strobe),
    .i_reg_ready      (reg_ready),
    .i_reg_status     (reg_status),
    .i_reg_read_data  (reg_read_data)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int k, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] s);
    req_valid[k]            = v;
    req_write[k]            = w;
    req_address[k*AW +: AW] = a;
    req_write_data[k*DW +: DW] = d;
    req_strobe[k*DW +: DW]  = s;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    req_valid      = '0;
    req_write      = '0;
    req_address    = '0;
    req_write_data = '0;
    req_strobe     = '0;
    reg_ready      = 1'b1;
    reg_status     = 2'b01;
    reg_read_data  = 32'h1234_5678;
    repeat (2) @(negedge clk);
    checks++; if (reg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", reg_valid); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if (req_status !== 2'b00) begin errors++; $display("FAIL reset_status got=%b exp=00", req_status); end
    checks++; if (req_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", req_read_data); end
    checks++; if (reg_address !== 8'h00 || reg_write !== 1'b0) begin errors++; $display("FAIL reset_addr got=%h/%0b exp=00/0", reg_address, reg_write); end
    checks++; if (reg_write_data !== 32'h0 || reg_strobe !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h/%h exp=0/0", reg_write_data, reg_strobe); end
    reg_ready  = 1'b0;
    reg_status = 2'b00;
    rst_n      = 1'b1;
    $display("test_reset: reset state observed");
  endtask

  task automatic test_single_read();
    after_edge();
    set_req(0, 1'b1, 1'b0, 8'h04, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (reg_valid !== 1'b0) begin errors++; $display("FAIL read_pre_valid got=%0b exp=0", reg_valid); end
    after_edge();  // grant edge
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        reg_ready     = 1'b1;
        reg_status    = 2'b00;
        reg_read_data = 32'hA5A5_0001;
      end
      @(negedge clk);
      checks++; if (reg_valid !== 1'b1 || reg_address !== 8'h04 || reg_write !== 1'b0) begin
        errors++; $display("FAIL read_bus_c%0d got=%0b/%h/%0b exp=1/04/0", c, reg_valid, reg_address, reg_write);
      end
      if (c < 3) begin
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL read_early_ready_c%0d got=%b exp=000", c, req_ready); end
        after_edge();
      end else begin
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL read_ready got=%b exp=001", req_ready); end
        checks++; if (req_read_data !== 32'hA5A5_0001 || req_status !== 2'b00) begin
          errors++; $display("FAIL read_data got=%h/%b exp=a5a50001/00", req_read_data, req_status);
        end
      end
    end
    $display("test_single_read: req0 addr=04 rdata=%h ready=%b", req_read_data, req_ready);
    after_edge();
    reg_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (reg_valid !== 1'b0 || req_ready !== 3'b000) begin errors++; $display("FAIL read_idle got=%0b/%b exp=0/000", reg_valid, req_ready); end
    checks++; if (req_read_data !== 32'h0) begin errors++; $display("FAIL read_idle_rdata got=%h exp=0", req_read_data); end
  endtask

  task automatic test_write_latching();
    after_edge();
    set_req(1, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0000_FFFF);
    after_edge();  // granted, now BUSY
    set_req(1, 1'b1, 1'b1, 8'h20, 32'h1234_5678, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++; if (reg_write_data !== 32'hDEAD_BEEF || reg_strobe !== 32'h0000_FFFF) begin
      errors++; $display("FAIL wr_latch got=%h/%h exp=deadbeef/0000ffff", reg_write_data, reg_strobe);
    end
    checks++; if (reg_address !== 8'h10 || reg_write !== 1'b1 || reg_valid !== 1'b1) begin
      errors++; $display("FAIL wr_bus got=%h/%0b/%0b exp=10/1/1", reg_address, reg_write, reg_valid);
    end
    after_edge();
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);  // valid dropped while BUSY
    reg_ready     = 1'b1;
    reg_status    = 2'b01;
    reg_read_data = 32'h0;
    @(negedge clk);
    checks++; if (req_ready !== 3'b010 || req_status !== 2'b01) begin
      errors++; $display("FAIL wr_ready got=%b/%b exp=010/01", req_ready, req_status);
    end
    checks++; if (reg_write_data !== 32'hDEAD_BEEF || reg_strobe !== 32'h0000_FFFF) begin
      errors++; $display("FAIL wr_hold got=%h/%h exp=deadbeef/0000ffff", reg_write_data, reg_strobe);
    end
    $display("test_write_latching: req1 wdata=%h strobe=%h ready=%b", reg_write_data, reg_strobe, req_ready);
    after_edge();
    reg_ready  = 1'b0;
    reg_status = 2'b00;
    @(negedge clk);
    checks++; if (reg_valid !== 1'b0) begin errors++; $display("FAIL wr_idle got=%0b exp=0", reg_valid); end
  endtask

  task automatic test_rotation();
    after_edge();
    set_req(0, 1'b1, 1'b0, 8'h30, 32'h0, 32'h0);
    set_req(2, 1'b1, 1'b0, 8'h50, 32'h0, 32'h0);
    after_edge();  // req2 granted (pointer was 1)
    reg_ready     = 1'b1;
    reg_read_data = 32'h2222_0002;
    @(negedge clk);
    checks++; if (reg_address !== 8'h50 || req_ready !== 3'b100) begin
      errors++; $display("FAIL rot_first got=%h/%b exp=50/100", reg_address, req_ready);
    end
    checks++; if (req_read_data !== 32'h2222_0002) begin errors++; $display("FAIL rot_first_rdata got=%h exp=22220002", req_read_data); end
    $display("test_rotation: first grant addr=%h ready=%b", reg_address, req_ready);
    after_edge();  // completion edge, back to IDLE
    set_req(2, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    reg_read_data = 32'h0000_3000;
    @(negedge clk);
    checks++; if (reg_valid !== 1'b0 || req_ready !== 3'b000) begin
      errors++; $display("FAIL rot_gap got=%0b/%b exp=0/000", reg_valid, req_ready);
    end
    after_edge();  // req0 granted
    @(negedge clk);
    checks++; if (reg_address !== 8'h30 || req_ready !== 3'b001 || req_read_data !== 32'h0000_3000) begin
      errors++; $display("FAIL rot_second got=%h/%b/%h exp=30/001/00003000", reg_address, req_ready, req_read_data);
    end
    $display("test_rotation: second grant addr=%h ready=%b", reg_address, req_ready);
    after_edge();
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    reg_ready = 1'b0;
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_rdy;
    int           g;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    after_edge();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, 8'(8'h40 + k), 32'h0, 32'h0);
    reg_ready     = 1'b1;
    reg_read_data = 32'h0;
    @(negedge clk);
    checks++; if (reg_valid !== 1'b0) begin errors++; $display("FAIL cont_start got=%0b exp=0", reg_valid); end
    for (int k = 0; k < 6; k++) begin
      g = k % N;
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      @(negedge clk);
      checks++; if (reg_valid !== 1'b1 || req_ready !== exp_rdy || reg_address !== 8'(8'h40 + g)) begin
        errors++; $display("FAIL cont_grant%0d got=%0b/%b/%h exp=1/%b/%h", k, reg_valid, req_ready, reg_address, exp_rdy, 8'(8'h40 + g));
      end
      $display("test_contention: access %0d granted ready=%b addr=%h", k, req_ready, reg_address);
      @(negedge clk);
      checks++; if (reg_valid !== 1'b0 || req_ready !== 3'b000) begin
        errors++; $display("FAIL cont_idle%0d got=%0b/%b exp=0/000", k, reg_valid, req_ready);
      end
    end
    req_valid = '0;
    reg_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    after_edge();
    set_req(1, 1'b1, 1'b0, 8'h60, 32'h0, 32'h0);
    after_edge();  // req1 granted
    @(negedge clk);
    checks++; if (reg_valid !== 1'b1 || reg_address !== 8'h60) begin
      errors++; $display("FAIL rmid_busy got=%0b/%h exp=1/60", reg_valid, reg_address);
    end
    #2;
    rst_n     = 1'b0;
    reg_ready = 1'b1;
    #1;
    checks++; if (reg_valid !== 1'b0 || req_ready !== 3'b000 || reg_address !== 8'h00) begin
      errors++; $display("FAIL rmid_async got=%0b/%b/%h exp=0/000/00", reg_valid, req_ready, reg_address);
    end
    $display("test_reset_mid: access aborted valid=%0b ready=%b", reg_valid, req_ready);
    @(negedge clk);
    rst_n     = 1'b1;
    reg_ready = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, 8'(8'h70 + k), 32'h0, 32'h0);
    after_edge();
    @(negedge clk);
    checks++; if (reg_valid !== 1'b1 || reg_address !== 8'h70) begin
      errors++; $display("FAIL rmid_first got=%0b/%h exp=1/70", reg_valid, reg_address);
    end
    reg_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rmid_ready got=%b exp=001", req_ready); end
    after_edge();
    req_valid = '0;
    reg_ready = 1'b0;
  endtask

`ifdef RGGEN_ARB_TIMEOUT_EN
  task automatic test_timeout();
    after_edge();
    set_req(1, 1'b1, 1'b0, 8'h80, 32'h0, 32'h0);
    reg_ready     = 1'b0;
    reg_status    = 2'b11;
    reg_read_data = 32'hDEAD_0000;
    after_edge();  // granted, counter at zero
    for (int c = 0; c <= TO; c++) begin
      @(negedge clk);
      checks++; if (reg_valid !== 1'b1) begin errors++; $display("FAIL to_valid_c%0d got=%0b exp=1", c, reg_valid); end
      if (c < TO) begin
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL to_early_c%0d got=%b exp=000", c, req_ready); end
      end else begin
        checks++; if (req_ready !== 3'b010 || req_status !== 2'b10 || req_read_data !== 32'h0) begin
          errors++; $display("FAIL to_pulse got=%b/%b/%h exp=010/10/0", req_ready, req_status, req_read_data);
        end
        $display("test_timeout: timeout ready=%b status=%b", req_ready, req_status);
      end
      after_edge();
    end
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (reg_valid !== 1'b0 || req_ready !== 3'b000) begin
      errors++; $display("FAIL to_idle got=%0b/%b exp=0/000", reg_valid, req_ready);
    end
    reg_status = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write_latching();
    test_rotation();
    test_contention();
    test_reset_mid();
`ifdef RGGEN_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rggen_sw_access_arbiter.md
Name: rggen_sw_access_arbiter

Overview:
- Shares the single software access port of a generated register block between N requesters, for example a host bus bridge, a debug port and a boot-time config loader.
- Each requester uses a valid/ready request handshake.
- The arbiter picks one requester by round-robin, latches its request, and drives it on the register-block access bus. It then returns status and read data to that requester when the register block responds.
- Sits between the bus bridges and the register block top, upstream of every bit-field instance.

Parameters:
- N, 2, number of requesters; legal range 2..8.
- ADDRESS_WIDTH, 8, byte address width.
- DATA_WIDTH, 32, data and strobe width.
- TIMEOUT_CYCLES, 255, timeout cycle count; used only with the optional feature; legal range 1..65535.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_req_valid  in  N  request valid, one bit per requester.
- i_req_write  in  N  1 = write, 0 = read.
- i_req_address  in  N*ADDRESS_WIDTH  packed addresses; requester k uses slice [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- i_req_write_data  in  N*DATA_WIDTH  packed write data.
- i_req_strobe  in  N*DATA_WIDTH  packed per-bit write mask.
- o_req_ready  out  N  one-hot completion pulse.
- o_req_status  out  2  response status, shared by all requesters, qualified by o_req_ready.
- o_req_read_data  out  DATA_WIDTH  read data, shared by all requesters, qualified by o_req_ready.
- o_reg_valid  out  1  access valid to the register block.
- o_reg_write  out  1  access direction.
- o_reg_address  out  ADDRESS_WIDTH  latched address.
- o_reg_write_data  out  DATA_WIDTH  latched write data.
- o_reg_strobe  out  DATA_WIDTH  latched strobe.
- i_reg_ready  in  1  register block access done.
- i_reg_status  in  2  status: 00 OKAY, 01 EXOKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR.
- i_reg_read_data  in  DATA_WIDTH  read data.

Behaviour:
- Reset values:
  - state = IDLE.
  - round-robin pointer = N-1, so requester 0 has highest priority first.
  - o_reg_valid = 0.
  - o_req_ready = 0.
  - all latched fields = 0.
  - o_req_status = 00 and o_req_read_data = 0 while ready is low.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any i_req_valid bit is set, grant the first set bit at or after (pointer+1) mod N, scanning upward with wrap.
  - On the same edge, latch the grant index, write, address, write data and strobe, and go to BUSY.
  - If no bit is set, stay in IDLE.
- BUSY:
  - o_reg_valid = 1 and all o_reg_* fields are driven from the latches. They must not change while in BUSY.
  - In a cycle where i_reg_ready = 1:
    - o_req_ready[grant] = 1 in that same cycle (combinational).
    - o_req_status = i_reg_status and o_req_read_data = i_reg_read_data, passed through.
  - On that edge: pointer = grant, state = IDLE.
- Latency:
  - Request sampled at edge 0 → o_reg_valid high from edge 0 until the completion cycle.
  - Minimum request-to-ready time is 2 cycles, when the register block responds in its first valid cycle.
  - At least one IDLE cycle separates consecutive accesses.
- Requester rules:
  - A requester must hold valid and its fields stable until it sees its ready bit.
  - The arbiter samples the request once. If valid is dropped during BUSY, the access still completes and the ready pulse is still issued.
- Simultaneous events:
  - A request arriving while BUSY waits.
  - A pointer update and a new selection never occur on the same edge.
- Fairness: with all N requesters requesting continuously, each is granted exactly once every N accesses.
- A write with an all-zero strobe is forwarded unchanged; the register block decides the outcome.
- Reset mid-access: everything returns to reset values immediately. No ready pulse is issued for the aborted access.

Optional Feature:
- Macro: RGGEN_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle in which i_reg_ready = 0.
  - When the count reaches TIMEOUT_CYCLES with i_reg_ready still 0, that cycle is the completion cycle:
    - o_req_ready[grant] = 1.
    - o_req_status = 10.
    - o_req_read_data = 0.
    - o_reg_valid stays high for that cycle, then the FSM returns to IDLE and the pointer updates as normal.
  - If i_reg_ready arrives in the same cycle as the timeout, the real response wins.
- Undefined: no counter is instantiated, and the arbiter waits indefinitely in BUSY.

Test Plan:
- Single read, N=2: req0 reads address 0x04; the register block answers after 3 cycles with data 0xA5A5_0001, status 00 → o_reg_valid held 3 cycles with address 0x04 and write 0, then o_req_ready = 01 for one cycle with data 0xA5A5_0001.
- Contention, N=3: after reset, all three requesters are valid continuously and each access gets an immediate ready → grant order 0,1,2,0,1,2 with exactly one IDLE cycle between accesses.
- Priority rotation: after req1 completes, req0 and req2 request simultaneously → req2 is granted first.
- Write latching: req1 writes 0xDEAD_BEEF with strobe 0x0000_FFFF, then changes its data while BUSY → o_reg_write_data stays 0xDEAD_BEEF and o_reg_strobe stays 0x0000_FFFF until ready.
- Reset mid-access: i_rst_n is asserted while BUSY → o_reg_valid drops to 0 asynchronously, o_req_ready stays 0, and the first grant after reset goes to req0.
- Timeout, macro defined with TIMEOUT_CYCLES=4: i_reg_ready held at 0 → the ready pulse for the granted requester arrives with status 10 and read data 0, after which the arbiter returns to IDLE.
